// File: rtl/img_pkg.sv
// Shared encodings and types for the image-SRAM custom-instruction interface.
package img_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'h33;
  localparam logic [6:0] F7_IMG     = 7'h06;
  localparam logic [2:0] F3_IM_WR   = 3'b000;
  localparam logic [2:0] F3_IM_RD   = 3'b001;
  localparam logic [2:0] F3_IM_STAT = 3'b010;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StRdIssue,
    StRdWait,
    StRdOut
  } state_e;

  // R-type word with rs1/rs2 fields zero; operands travel on rs1_val/rs2_val.
  function automatic logic [31:0] img_instr(input logic [2:0] funct3, input logic [4:0] rd);
    return {F7_IMG, 5'd0, 5'd0, funct3, rd, OPC_RTYPE};
  endfunction

endpackage

// File: rtl/img_burst_issuer.sv
// Turns one tile command into a raster sequence of IM_WR / IM_RD instructions.
module img_burst_issuer
  import img_pkg::*;
#(
  parameter int unsigned IMG_H   = 255,
  parameter int unsigned IMG_W   = 255,
  parameter int unsigned DATA_W  = 32,
  parameter logic [4:0]  RD_REG  = 5'd10,
  parameter int unsigned TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [15:0]       cmd_row0,
  input  logic [15:0]       cmd_col0,
  input  logic [15:0]       cmd_h,
  input  logic [15:0]       cmd_w,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rdo_valid,
  input  logic              rdo_ready,
  output logic [DATA_W-1:0] rdo_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       rs1_val,
  output logic [31:0]       rs2_val,
  output logic [4:0]        rd_addr,
  input  logic              rd_we,
  input  logic [4:0]        rd_waddr,
  input  logic [31:0]       rd_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned     TMO_W    = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_e            state_q, state_d;
  logic [15:0]       row0_q, col0_q, h_q, w_q, r_q, c_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [DATA_W-1:0] rdo_data_q;
  logic              done_q, done_d, err_q, err_d;
  logic              load, advance, tmo_clr, cap;
  logic              cmd_bad, last, rsp;

  // 17-bit sums so an origin near 0xFFFF cannot wrap past the bound.
  assign cmd_bad = (cmd_h == 16'd0) || (cmd_w == 16'd0) ||
                   (({1'b0, cmd_row0} + {1'b0, cmd_h}) > 17'(IMG_H)) ||
                   (({1'b0, cmd_col0} + {1'b0, cmd_w}) > 17'(IMG_W));
  assign last    = (r_q == h_q - 16'd1) && (c_q == w_q - 16'd1);
  assign rsp     = rd_we && (rd_waddr == RD_REG);

  assign rs1_val  = {row0_q + r_q, col0_q + c_q};
  assign rd_addr  = instr[11:7];
  assign rdo_data = rdo_data_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;

  // Next-state, handshakes and instruction encoding.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    instr_valid = 1'b0;
    wr_ready    = 1'b0;
    rdo_valid   = 1'b0;
    instr       = img_instr(F3_IM_RD, RD_REG);
    rs2_val     = 32'd0;
    load        = 1'b0;
    advance     = 1'b0;
    tmo_clr     = 1'b0;
    cap         = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = (op_e'(cmd_op) == OP_RD) ? StRdIssue : StWrIssue;
          end
        end
      end
      StWrIssue: begin
        instr       = img_instr(F3_IM_WR, 5'd0);
        instr_valid = wr_valid;
        wr_ready    = instr_ready;
        rs2_val     = 32'(wr_data);
        if (wr_valid && instr_ready) begin
          advance = 1'b1;
          if (last) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRdIssue: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          tmo_clr = 1'b1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (rsp) begin
          cap     = 1'b1;
          state_d = StRdOut;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StRdOut: begin
        rdo_valid = 1'b1;
        if (rdo_ready) begin
          advance = 1'b1;
          if (last) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRdIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, status pulses, read timeout and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      rdo_data_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (tmo_clr) begin
        tmo_q <= '0;
      end else if (state_q == StRdWait) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (cap) begin
        rdo_data_q <= DATA_W'(rd_wdata);
      end
    end
  end

  // Latched command fields and raster row/column counter (column is fast).
  always_ff @(posedge clk) begin
    if (rst) begin
      row0_q <= '0;
      col0_q <= '0;
      h_q    <= '0;
      w_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
    end else if (load) begin
      row0_q <= cmd_row0;
      col0_q <= cmd_col0;
      h_q    <= cmd_h;
      w_q    <= cmd_w;
      r_q    <= '0;
      c_q    <= '0;
    end else if (advance) begin
      if (c_q == w_q - 16'd1) begin
        c_q <= '0;
        r_q <= r_q + 16'd1;
      end else begin
        c_q <= c_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_img_burst_issuer.sv
// Directed bench for img_burst_issuer with a small image-interface read model.
module tb_img_burst_issuer;

  localparam logic [31:0] INS_WR = 32'h0C000033;
  localparam logic [31:0] INS_RD = 32'h0C001533;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [15:0] cmd_row0, cmd_col0, cmd_h, cmd_w;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rdo_valid, rdo_ready;
  logic [31:0] rdo_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, rs1_val, rs2_val;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        busy, done, err;

  img_burst_issuer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row0(cmd_row0), .cmd_col0(cmd_col0), .cmd_h(cmd_h), .cmd_w(cmd_w),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rdo_valid(rdo_valid), .rdo_ready(rdo_ready), .rdo_data(rdo_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cmd_cyc = 0;
  bit stub_dead = 1'b0;

  logic [31:0] acc_rs1[$], acc_rs2[$], acc_ins[$], beat_dat[$];
  int          acc_cyc[$], beat_cyc[$], done_cyc[$], err_cyc[$];
  int          both_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel value the model image holds at {row, col}.
  function automatic logic [31:0] pix(input logic [31:0] a);
    return 32'hA0 + {16'd0, a[15:0]} + (32'(a[31:16]) << 8);
  endfunction

  // Image-interface read model: IM_RD accepted in T answers with rd_we in T+3.
  logic [1:0]  rv;
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    if (rst) begin
      rv       <= '0;
      rd_we    <= 1'b0;
      rd_waddr <= '0;
      rd_wdata <= '0;
    end else begin
      rv       <= {rv[0], instr_valid && instr_ready && (instr[14:12] == 3'b001)};
      p1       <= pix(rs1_val);
      p2       <= p1;
      rd_we    <= rv[1];
      rd_waddr <= stub_dead ? 5'd3 : 5'd10;
      rd_wdata <= p2;
    end
  end

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_ready) begin
        acc_rs1.push_back(rs1_val);
        acc_rs2.push_back(rs2_val);
        acc_ins.push_back(instr);
        acc_cyc.push_back(cyc);
      end
      if (rdo_valid && rdo_ready) begin
        beat_dat.push_back(rdo_data);
        beat_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (err) err_cyc.push_back(cyc);
      if (done && err) both_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    acc_rs1.delete(); acc_rs2.delete(); acc_ins.delete(); acc_cyc.delete();
    beat_dat.delete(); beat_cyc.delete(); done_cyc.delete(); err_cyc.delete();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic issue_cmd(input logic op, input logic [15:0] r0, input logic [15:0] c0,
                           input logic [15:0] h, input logic [15:0] w);
    int g = 0;
    cmd_op = op; cmd_row0 = r0; cmd_col0 = c0; cmd_h = h; cmd_w = w;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) begin
        cmd_cyc = cyc;
        break;
      end
      g++;
      if (g > 100) break;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("cmd_accept_budget", 32'(g > 100), 32'd0);
  endtask

  task automatic wait_idle(input int max);
    int g = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      g++;
      if (g > max) break;
    end
    check_eq("idle_budget", 32'(g > max), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input int n, input bit rnd);
    int  sent = 0;
    int  g    = 0;
    bit  hs;
    wr_valid = 1'b1; wr_data = 32'd0; instr_ready = 1'b1;
    while (sent < n && g < 500) begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk); #1;
      g++;
      if (hs) begin
        sent++;
        wr_data = wr_data + 32'd1;
      end
      if (rnd) begin
        wr_valid    = 1'($urandom_range(0, 1));
        instr_ready = 1'($urandom_range(0, 1));
      end
    end
    wr_valid = 1'b0; instr_ready = 1'b1;
    check_eq("wr_budget", 32'(g >= 500), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_row0 = '0; cmd_col0 = '0; cmd_h = '0; cmd_w = '0;
    wr_valid = 1'b0; wr_data = '0; rdo_ready = 1'b1; instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_rdo_valid", 32'(rdo_valid), 32'd0);
    check_eq("rst_done_err", {30'd0, done, err}, 32'd0);
    check_eq("rst_rdo_data", rdo_data, 32'd0);
    check_eq("idle_instr", instr, INS_RD);
    check_eq("idle_rd_addr", 32'(rd_addr), 32'd10);
    @(posedge clk); #1;

    // Write 2x3 at (5,7)
    clear_mon();
    issue_cmd(1'b0, 16'd5, 16'd7, 16'd2, 16'd3);
    drive_write(6, 1'b0);
    wait_idle(50);
    check_eq("w23_count", 32'(acc_rs1.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_rs1.size(); i++) begin
      check_eq($sformatf("w23_rs1_%0d", i), acc_rs1[i],
               {16'(5 + i / 3), 16'(7 + i % 3)});
      check_eq($sformatf("w23_rs2_%0d", i), acc_rs2[i], 32'(i));
      check_eq($sformatf("w23_instr_%0d", i), acc_ins[i], INS_WR);
      check_eq($sformatf("w23_cyc_%0d", i), 32'(acc_cyc[i]), 32'(qget(acc_cyc, 0) + i));
    end
    check_eq("w23_done_cnt", 32'(done_cyc.size()), 32'd1);
    check_eq("w23_done_cyc", 32'(qget(done_cyc, 0)), 32'(qget(acc_cyc, 5) + 1));
    check_eq("w23_err_cnt", 32'(err_cyc.size()), 32'd0);

    // Write 4x4 at (10,20) with random backpressure on both sides
    clear_mon();
    issue_cmd(1'b0, 16'd10, 16'd20, 16'd4, 16'd4);
    drive_write(16, 1'b1);
    wait_idle(50);
    check_eq("bp_count", 32'(acc_rs1.size()), 32'd16);
    for (int i = 0; i < 16 && i < acc_rs1.size(); i++) begin
      check_eq($sformatf("bp_rs1_%0d", i), acc_rs1[i], {16'(10 + i / 4), 16'(20 + i % 4)});
      check_eq($sformatf("bp_rs2_%0d", i), acc_rs2[i], 32'(i));
    end
    check_eq("bp_done_cnt", 32'(done_cyc.size()), 32'd1);

    // Read 1x4 at (0,0)
    clear_mon();
    rdo_ready = 1'b1; instr_ready = 1'b1;
    issue_cmd(1'b1, 16'd0, 16'd0, 16'd1, 16'd4);
    wait_idle(100);
    check_eq("rd_issue_cnt", 32'(acc_ins.size()), 32'd4);
    check_eq("rd_instr", (acc_ins.size() > 0) ? acc_ins[0] : 32'hX, INS_RD);
    check_eq("rd_beat_cnt", 32'(beat_dat.size()), 32'd4);
    for (int i = 0; i < 4 && i < beat_dat.size(); i++) begin
      check_eq($sformatf("rd_data_%0d", i), beat_dat[i], 32'hA0 + 32'(i));
      check_eq($sformatf("rd_lat_%0d", i), 32'(beat_cyc[i]), 32'(qget(acc_cyc, i) + 4));
      if (i > 0)
        check_eq($sformatf("rd_space_%0d", i), 32'(beat_cyc[i] - beat_cyc[i-1]), 32'd5);
    end
    check_eq("rd_done_cnt", 32'(done_cyc.size()), 32'd1);
    check_eq("rd_done_cyc", 32'(qget(done_cyc, 0)), 32'(qget(beat_cyc, 3) + 1));

    // Bad commands: row overflow, then zero width
    clear_mon();
    issue_cmd(1'b0, 16'd250, 16'd0, 16'd10, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bad_row_err_cnt", 32'(err_cyc.size()), 32'd1);
    check_eq("bad_row_err_cyc", 32'(qget(err_cyc, 0)), 32'(cmd_cyc + 1));
    check_eq("bad_row_no_instr", 32'(acc_rs1.size()), 32'd0);
    check_eq("bad_row_cmd_ready", 32'(cmd_ready), 32'd1);
    clear_mon();
    issue_cmd(1'b1, 16'd0, 16'd0, 16'd1, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bad_w0_err_cnt", 32'(err_cyc.size()), 32'd1);
    check_eq("bad_w0_err_cyc", 32'(qget(err_cyc, 0)), 32'(cmd_cyc + 1));
    check_eq("bad_w0_no_instr", 32'(acc_rs1.size()), 32'd0);
    check_eq("bad_w0_busy", 32'(busy), 32'd0);

    // Boundary: 1x1 write at the last row/column is legal
    clear_mon();
    issue_cmd(1'b0, 16'd254, 16'd254, 16'd1, 16'd1);
    drive_write(1, 1'b0);
    wait_idle(20);
    check_eq("edge_count", 32'(acc_rs1.size()), 32'd1);
    check_eq("edge_rs1", (acc_rs1.size() > 0) ? acc_rs1[0] : 32'hX, 32'h00FE00FE);
    check_eq("edge_err_cnt", 32'(err_cyc.size()), 32'd0);
    check_eq("edge_done_cnt", 32'(done_cyc.size()), 32'd1);

    // Read timeout: only wrong-tag write-backs arrive
    clear_mon();
    stub_dead = 1'b1;
    issue_cmd(1'b1, 16'd0, 16'd0, 16'd1, 16'd1);
    wait_idle(60);
    stub_dead = 1'b0;
    check_eq("tmo_issue_cnt", 32'(acc_ins.size()), 32'd1);
    check_eq("tmo_err_cnt", 32'(err_cyc.size()), 32'd1);
    check_eq("tmo_err_cyc", 32'(qget(err_cyc, 0)), 32'(qget(acc_cyc, 0) + 16));
    check_eq("tmo_no_done", 32'(done_cyc.size()), 32'd0);
    check_eq("tmo_no_beat", 32'(beat_dat.size()), 32'd0);

    // Reset mid-write, then a clean tile
    clear_mon();
    issue_cmd(1'b0, 16'd1, 16'd1, 16'd4, 16'd4);
    wr_valid = 1'b1; wr_data = 32'h55; instr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("mid_rst_rdo_valid", 32'(rdo_valid), 32'd0);
    check_eq("mid_rst_done_err", {30'd0, done, err}, 32'd0);
    check_eq("mid_rst_rdo_data", rdo_data, 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    clear_mon();
    issue_cmd(1'b0, 16'd3, 16'd4, 16'd1, 16'd2);
    drive_write(2, 1'b0);
    wait_idle(20);
    check_eq("post_rst_count", 32'(acc_rs1.size()), 32'd2);
    check_eq("post_rst_rs1_0", (acc_rs1.size() > 0) ? acc_rs1[0] : 32'hX, 32'h00030004);
    check_eq("post_rst_rs1_1", (acc_rs1.size() > 1) ? acc_rs1[1] : 32'hX, 32'h00030005);
    check_eq("post_rst_done_cnt", 32'(done_cyc.size()), 32'd1);

    check_eq("done_err_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/img_burst_issuer.md
# img_burst_issuer

Upstream command sequencer for the image-SRAM custom-instruction interface. It turns one rectangular-tile command into a raster sequence of `IM_WR` or `IM_RD` R-type instructions (opcode 0x33, funct7 0x06). It drives the interface's instruction handshake and consumes its `rd_we` write-back. It feeds tile data in from a valid/ready stream (write) or returns read data on a valid/ready stream (read), so DMA/loader logic can fill or drain the image buffer without the CPU.

## Interface
- `IMG_H`, 255, image rows; valid row index 0..IMG_H-1
- `IMG_W`, 255, image columns; valid column index 0..IMG_W-1
- `DATA_W`, 32, pixel width (fp32 bits)
- `RD_REG`, 5'd10, destination register tag used for `IM_RD`
- `TMO_CYC`, 15, maximum cycles to wait for a read response
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `cmd_valid` in 1 / `cmd_ready` out 1: tile command handshake
- `cmd_op` in 1: 0 = write tile, 1 = read tile
- `cmd_row0`, `cmd_col0` in 16 each: tile origin
- `cmd_h`, `cmd_w` in 16 each: tile height and width
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in DATA_W: write pixel stream
- `rdo_valid` out 1 / `rdo_ready` in 1 / `rdo_data` out DATA_W: read pixel stream
- `instr_valid` out 1 / `instr_ready` in 1 / `instr` out 32: instruction issue
- `rs1_val` out 32: {row, col}
- `rs2_val` out 32: write data
- `rd_addr` out 5: destination register tag
- `rd_we` in 1 / `rd_waddr` in 5 / `rd_wdata` in 32: write-back from the interface
- `busy` out 1: state ≠ IDLE
- `done` out 1: pulse when a tile completes
- `err` out 1: pulse on bad command or timeout

## Operation
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_OUT.
- **Command accept.** `cmd_ready` = (state == IDLE). On accept, latch all command fields and set the counters r = c = 0.
- **Bounds check** (17-bit sums). The command is bad if h == 0, w == 0, row0 + h > IMG_H, or col0 + w > IMG_W. A bad command gives an `err` pulse the next cycle, stays in IDLE, and issues no instruction.
- **Raster order.** Column is the fast index. Address = {row0 + r, col0 + c}. Last element is r == h-1 and c == w-1.
- **Instruction word.** instr = {7'h06, 5'd0, 5'd0, funct3, rd, 7'h33}.
  - Write: funct3 = 000, rd = 0.
  - Read: funct3 = 001, rd = RD_REG.
  - `rd_addr` equals the rd field of `instr`.
- **WR_ISSUE.**
  - `instr_valid` = `wr_valid`; `wr_ready` = `instr_ready`; `rs2_val` = `wr_data`.
  - On each accept (`instr_valid` && `instr_ready`), advance the counters.
  - Accept of the last element: go to IDLE and pulse `done`.
- **RD_ISSUE.** `instr_valid` = 1. On accept, go to RD_WAIT and clear the timeout counter.
- **RD_WAIT.**
  - A response is `rd_we` && `rd_waddr` == RD_REG. On a response, capture `rd_wdata` into `rdo_data` and go to RD_OUT.
  - `rd_we` with any other `rd_waddr` is ignored.
  - If TMO_CYC cycles pass with no response: pulse `err`, go to IDLE, abandon the tile, no `done`.
- **RD_OUT.**
  - `rdo_valid` = 1; `rdo_data` holds until the beat is accepted.
  - On `rdo_ready`, advance the counters. Last element: go to IDLE and pulse `done`. Otherwise go to RD_ISSUE.
- In IDLE, `instr_valid`, `wr_ready` and `rdo_valid` are 0. `instr` still carries the IM_RD/RD_REG encoding so the downstream `instr_ready` stays defined.
- **Reset.** Effective at any point, including mid-tile.
  - State goes to IDLE and the counters clear.
  - `done`, `err`, `rdo_valid`, `instr_valid` = 0; `rdo_data` = 0.
  - A partial tile is dropped.

## Timing
- **Write throughput.** One pixel per cycle while `wr_valid` and `instr_ready` are both high. `wr_ready` is combinational from `instr_ready` (there is no path from `instr_valid` to `instr_ready`).
- **Read latency.**
  - IM_RD accepted in cycle T.
  - `rd_we` arrives in cycle T+3.
  - `rdo_valid` rises in T+4.
  - With `rdo_ready` held high, the next IM_RD is issued in T+5, so one pixel per 5 cycles.
- **Done timing.** `done` rises the cycle after the final accept or output handshake. `busy` falls in the same cycle.
- **Back-to-back commands.** A new command can be accepted in the cycle `done` is high.
- **Pulses.** `done` and `err` are each exactly 1 cycle wide and are never high together.

## Structure
- Shared package `img_pkg`:
  - OPC_RTYPE = 7'h33, F7_IMG = 7'h06, F3_IM_WR, F3_IM_RD, F3_IM_STAT
  - op enum (OP_WR, OP_RD)
  - state enum
  - function `img_instr(funct3, rd)` returning the 32-bit instruction word
- Single module, no sub-modules. The row/column counter is an internal always_ff.

## Test plan
- **Write 2x3 tile.** Command: write, origin (5,7), 2x3, `wr_data` 0..5, `instr_ready` = 1 → six IM_WR on consecutive cycles with rs1 = 0x00050007, 0x00050008, 0x00050009, 0x00060007, 0x00060008, 0x00060009 and matching rs2; `done` 1 cycle after the last.
- **Write backpressure.** Toggle `wr_valid` and `instr_ready` randomly during a 4x4 write → no duplicate or skipped address, and 16 IM_WR total.
- **Read 1x4 tile.** Read at origin (0,0), 1x4, against the real interface pre-loaded with 0xA0..0xA3 → `rdo_data` = 0xA0..0xA3 in order, 5-cycle spacing, `done` after the 4th beat.
- **Bad commands.** Command with row0 = 250, h = 10 (IMG_H = 255), and one with w = 0 → each gives a 1-cycle `err`, no `instr_valid`, and `cmd_ready` is back high.
- **Timeout and reset.** Read with a stubbed interface that never asserts `rd_we` → `err` after 15 cycles and return to IDLE. Separately, assert `rst` mid-write → all outputs 0 the next cycle and the next command runs cleanly from r = c = 0.
